// File: rtl/l2_bus_sched.sv
// Shared L1->L2 bus scheduler: writeback-first round-robin ownership, fixed-length bursts
// paced by the L2 ready strobe, bounded back-to-back chaining via hold, one-cycle turnaround.
module l2_bus_sched #(
  parameter int N_REQ     = 3,
  parameter int BURST_LEN = 4,
  parameter int HOLD_MAX  = 4
) (
  input  logic                          i_plusclk,
  input  logic                          i_rst,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [N_REQ-1:0]              i_type,
  input  logic [N_REQ-1:0]              i_hold,
  input  logic                          i_l2_ready,
  output logic [N_REQ-1:0]              o_grant,
  output logic                          o_bus_busy,
  output logic [$clog2(N_REQ)-1:0]      o_bus_owner,
  output logic                          o_bus_wr,
  output logic [$clog2(BURST_LEN)-1:0]  o_beat_cnt,
  output logic                          o_burst_done,
  output logic                          o_burst_abort
);

  localparam int OW = $clog2(N_REQ);
  localparam int BW = $clog2(BURST_LEN);
  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef logic [OW-1:0]    own_t;
  typedef logic [BW-1:0]    beat_t;
  typedef logic [CW-1:0]    chain_t;
  typedef logic [N_REQ-1:0] req_t;
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

  localparam beat_t  LAST_BEAT = beat_t'(BURST_LEN - 1);
  localparam chain_t CHAIN_LIM = chain_t'(HOLD_MAX - 1);

  state_t r_state, w_state_nxt;
  req_t   r_grant, w_grant_nxt;
  logic   r_busy, w_busy_nxt;
  own_t   r_owner, w_owner_nxt;
  logic   r_wr, w_wr_nxt;
  beat_t  r_beat, w_beat_nxt;
  logic   r_done, w_done_nxt;
  logic   r_abort, w_abort_nxt;
  own_t   r_rr_ptr, w_rr_ptr_nxt;
  chain_t r_chain, w_chain_nxt;

  req_t   w_sel_mask;
  own_t   w_win;
  own_t   w_owner_inc;

  // First set bit of mask at or after start, wrapping N_REQ-1 -> 0.
  function automatic own_t rr_pick(input req_t mask, input own_t start);
    own_t win;
    logic found;
    int   idx;
    win   = start;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && mask[idx]) begin
        win   = own_t'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic own_t next_idx(input own_t o);
    int n;
    n = int'(o) + 1;
    if (n >= N_REQ) n = 0;
    return own_t'(n);
  endfunction

  assign w_sel_mask  = (|(i_req & i_type)) ? (i_req & i_type) : i_req;
  assign w_win       = rr_pick(w_sel_mask, r_rr_ptr);
  assign w_owner_inc = next_idx(r_owner);

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_busy_nxt   = r_busy;
    w_owner_nxt  = r_owner;
    w_wr_nxt     = r_wr;
    w_beat_nxt   = r_beat;
    w_done_nxt   = 1'b0;
    w_abort_nxt  = 1'b0;
    w_rr_ptr_nxt = r_rr_ptr;
    w_chain_nxt  = r_chain;
    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_state_nxt = S_XFER;
          w_grant_nxt = req_t'(1) << w_win;
          w_busy_nxt  = 1'b1;
          w_owner_nxt = w_win;
          w_wr_nxt    = i_type[w_win];
          w_beat_nxt  = '0;
          w_chain_nxt = '0;
        end
      end
      S_XFER: begin
        // Owner withdrawal takes precedence over any beat completing this cycle.
        if (!i_req[r_owner]) begin
          w_state_nxt  = S_GAP;
          w_grant_nxt  = '0;
          w_busy_nxt   = 1'b0;
          w_abort_nxt  = 1'b1;
          w_beat_nxt   = '0;
          w_rr_ptr_nxt = w_owner_inc;
        end else if (i_l2_ready) begin
          if (r_beat == LAST_BEAT) begin
            w_done_nxt = 1'b1;
            w_beat_nxt = '0;
            if (i_hold[r_owner] && (r_chain < CHAIN_LIM)) begin
              w_chain_nxt = r_chain + chain_t'(1);
              w_wr_nxt    = i_type[r_owner];
            end else begin
              w_state_nxt  = S_GAP;
              w_grant_nxt  = '0;
              w_busy_nxt   = 1'b0;
              w_rr_ptr_nxt = w_owner_inc;
            end
          end else begin
            w_beat_nxt = r_beat + beat_t'(1);
          end
        end
      end
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_plusclk) begin
    if (!i_rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_owner  <= '0;
      r_wr     <= 1'b0;
      r_beat   <= '0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      r_rr_ptr <= '0;
      r_chain  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_busy   <= w_busy_nxt;
      r_owner  <= w_owner_nxt;
      r_wr     <= w_wr_nxt;
      r_beat   <= w_beat_nxt;
      r_done   <= w_done_nxt;
      r_abort  <= w_abort_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_chain  <= w_chain_nxt;
    end
  end

  assign o_grant       = r_grant;
  assign o_bus_busy    = r_busy;
  assign o_bus_owner   = r_owner;
  assign o_bus_wr      = r_wr;
  assign o_beat_cnt    = r_beat;
  assign o_burst_done  = r_done;
  assign o_burst_abort = r_abort;

endmodule
